// File: rtl/noc_switch_pkg.sv
// noc_switch_pkg: shared state encoding, width helper and router port-count constants
package noc_switch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HELD = 2'd2
    } in_state_e;

    localparam int MESH_PORTS  = 5;
    localparam int TORUS_PORTS = 5;
    localparam int CMESH_PORTS = 8;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, first requester at or above ptr wins
//   req     : request vector
//   ptr     : index with highest priority this cycle
//   gnt     : one-hot grant
//   gnt_idx : index of the granted requester
//   any_gnt : some requester was granted
module rr_arbiter
    import noc_switch_pkg::*;
#(
    parameter int N = 5,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         any_gnt
);

    logic [W-1:0] j;

    // Scan offsets from far to near so the nearest requester above ptr overwrites the rest.
    always_comb begin
        j = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % N);
            if (req[j]) begin
                gnt_idx = j;
                any_gnt = 1'b1;
            end
        end
    end

    assign gnt = any_gnt ? N'(1) << gnt_idx : '0;

endmodule

// File: rtl/switch_allocator_rr.sv
// switch_allocator_rr: wormhole output-port allocator, round-robin per output, held head-to-tail
//   req_valid/req_dest : head flit request and destination per input
//   tail_release       : tail forwarded, free the held output
//   req_ack / req_err  : one-cycle pulses for reservation / out-of-range destination
//   in_locked          : input holds an output
//   route_sel          : crossbar select per output
//   out_busy           : output reserved
//   grant_cnt          : saturating grant count per output
module switch_allocator_rr
    import noc_switch_pkg::*;
#(
    parameter int INPUTS     = MESH_PORTS,
    parameter int OUTPUTS    = MESH_PORTS,
    parameter int SEL_WIDTH  = clog2_min1(INPUTS),
    parameter int DEST_WIDTH = clog2_min1(OUTPUTS),
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [INPUTS-1:0]             req_valid,
    input  logic [INPUTS*DEST_WIDTH-1:0]  req_dest,
    input  logic [INPUTS-1:0]             tail_release,
    output logic [INPUTS-1:0]             req_ack,
    output logic [INPUTS-1:0]             req_err,
    output logic [INPUTS-1:0]             in_locked,
    output logic [OUTPUTS*SEL_WIDTH-1:0]  route_sel,
    output logic [OUTPUTS-1:0]            out_busy,
    output logic [OUTPUTS*CNT_WIDTH-1:0]  grant_cnt
);

    logic [INPUTS-1:0][DEST_WIDTH-1:0]  dest_in, dest_q;
    in_state_e                          state_q [INPUTS];
    in_state_e                          state_d [INPUTS];
    logic [INPUTS-1:0]                  ack_q, err_q, won, dest_ok;
    logic [OUTPUTS-1:0]                 busy_q, rel_hit, any_gnt;
    logic [OUTPUTS-1:0][INPUTS-1:0]     cand, gnt, held_map;
    logic [OUTPUTS-1:0][SEL_WIDTH-1:0]  sel_q, gnt_idx, ptr_q;
    logic [OUTPUTS-1:0][CNT_WIDTH-1:0]  cnt_q;

    assign dest_in = req_dest;

    always_comb begin
        dest_ok = '0;
        for (int i = 0; i < INPUTS; i++)
            dest_ok[i] = int'(dest_in[i]) < OUTPUTS;
    end

    // A busy output arbitrates nothing, so a release frees it only from the following cycle.
    always_comb begin
        cand = '0;
        held_map = '0;
        rel_hit = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            for (int i = 0; i < INPUTS; i++) begin
                cand[o][i] = state_q[i] == REQ && int'(dest_q[i]) == o && !busy_q[o];
                held_map[o][i] = state_q[i] == HELD && int'(dest_q[i]) == o;
                rel_hit[o] = rel_hit[o] | (held_map[o][i] & tail_release[i]);
            end
        end
    end

    for (genvar o = 0; o < OUTPUTS; o++) begin : g_arb
        rr_arbiter #(
            .N (INPUTS),
            .W (SEL_WIDTH)
        ) u_arb (
            .req     (cand[o]),
            .ptr     (ptr_q[o]),
            .gnt     (gnt[o]),
            .gnt_idx (gnt_idx[o]),
            .any_gnt (any_gnt[o])
        );
    end

    // Each requesting input targets one output, so at most one arbiter can grant it.
    always_comb begin
        won = '0;
        for (int o = 0; o < OUTPUTS; o++)
            won = won | gnt[o];
    end

    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                IDLE:    if (req_valid[i] && dest_ok[i]) state_d[i] = REQ;
                REQ:     if (won[i]) state_d[i] = HELD;
                HELD:    if (tail_release[i]) state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < INPUTS; i++)
            in_locked[i] = state_q[i] == HELD;
        req_ack = ack_q;
        req_err = err_q;
        route_sel = sel_q;
        out_busy = busy_q;
        grant_cnt = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < INPUTS; i++)
                state_q[i] <= IDLE;
            dest_q <= '0;
            ack_q <= '0;
            err_q <= '0;
            busy_q <= '0;
            sel_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < INPUTS; i++) begin
                state_q[i] <= state_d[i];
                dest_q[i] <= state_q[i] == IDLE ? dest_in[i] : dest_q[i];
                ack_q[i] <= state_q[i] == REQ && won[i];
                err_q[i] <= state_q[i] == IDLE && req_valid[i] && !dest_ok[i];
            end
            for (int o = 0; o < OUTPUTS; o++) begin
                busy_q[o] <= any_gnt[o] | (busy_q[o] & ~rel_hit[o]);
                sel_q[o] <= any_gnt[o] ? gnt_idx[o] : sel_q[o];
                ptr_q[o] <= !any_gnt[o] ? ptr_q[o] :
                            int'(gnt_idx[o]) == INPUTS - 1 ? '0 : gnt_idx[o] + SEL_WIDTH'(1);
                cnt_q[o] <= any_gnt[o] && !(&cnt_q[o]) ? cnt_q[o] + CNT_WIDTH'(1) : cnt_q[o];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int o = 0; o < OUTPUTS; o++) begin
                assert ($countones(held_map[o]) <= 1);
                assert (busy_q[o] == |held_map[o]);
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator_rr.sv
// tb_switch_allocator_rr: table-driven and sequence checks of the round-robin switch allocator
module tb_switch_allocator_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req_valid, tail_release, req_ack, req_err, in_locked, out_busy;
    logic [14:0] req_dest, route_sel;
    logic [79:0] grant_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  valid;
        logic [14:0] dest;
        logic [4:0]  rel;
        logic [4:0]  ack;
        logic [4:0]  err;
        logic [4:0]  locked;
        logic [4:0]  busy;
    } vec_t;

    vec_t vecs [24];

    switch_allocator_rr dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_dest     (req_dest),
        .tail_release (tail_release),
        .req_ack      (req_ack),
        .req_err      (req_err),
        .in_locked    (in_locked),
        .route_sel    (route_sel),
        .out_busy     (out_busy),
        .grant_cnt    (grant_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] dests(input int d0, d1, d2, d3, d4);
        return {3'(d4), 3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    endfunction

    function automatic vec_t mk(input logic [4:0] v, input logic [14:0] d, input logic [4:0] r,
                                input logic [4:0] a, e, l, b);
        vec_t t;
        t.valid = v;
        t.dest = d;
        t.rel = r;
        t.ack = a;
        t.err = e;
        t.locked = l;
        t.busy = b;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_dest = '0;
        tail_release = '0;
        step();
        rst = 1'b0;
    endtask

    // Inputs 0, 1 and 4 contend for output 1; each holder releases three cycles after its ack.
    task automatic rr_order(input int e0, input int e1, input int e2);
        int exp_q [3];
        int got;
        int wait_n;
        int holder;
        exp_q = '{e0, e1, e2};
        got = 0;
        wait_n = -1;
        holder = 0;
        req_valid = 5'b10011;
        req_dest = dests(1, 1, 0, 0, 1);
        step();
        req_valid = '0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            tail_release = '0;
            if (wait_n == 0) tail_release[holder] = 1'b1;
            step();
            if (wait_n >= 0) wait_n--;
            if (req_ack != '0) begin
                check($sformatf("rr_grant%0d", got), 128'(req_ack), 128'(5'b00001 << exp_q[got]));
                for (int i = 0; i < 5; i++)
                    if (req_ack[i]) holder = i;
                got++;
                wait_n = 3;
            end
        end
        check("rr_grants_seen", 128'(got), 128'(3));
        tail_release = '0;
        tail_release[holder] = 1'b1;
        step();
        tail_release = '0;
    endtask

    initial begin
        vecs[0]  = mk(5'b00100, dests(0,0,3,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        vecs[1]  = mk(5'b00000, dests(0,0,0,0,0), 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b01000);
        vecs[2]  = mk(5'b00000, dests(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b01000);
        vecs[3]  = mk(5'b00000, dests(0,0,0,0,0), 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        vecs[4]  = mk(5'b00001, dests(7,0,0,0,0), 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000);
        vecs[5]  = mk(5'b00000, dests(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        vecs[6]  = mk(5'b00111, dests(1,2,3,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        vecs[7]  = mk(5'b00000, dests(0,0,0,0,0), 5'b00000, 5'b00111, 5'b00000, 5'b00111, 5'b01110);
        vecs[8]  = mk(5'b00000, dests(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00111, 5'b01110);
        vecs[9]  = mk(5'b00000, dests(0,0,0,0,0), 5'b00111, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        vecs[10] = mk(5'b00001, dests(2,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        vecs[11] = mk(5'b01000, dests(0,0,0,2,0), 5'b00000, 5'b00001, 5'b00000, 5'b00001, 5'b00100);
        vecs[12] = mk(5'b00000, dests(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00100);
        vecs[13] = mk(5'b00000, dests(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00100);
        vecs[14] = mk(5'b00000, dests(0,0,0,0,0), 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        vecs[15] = mk(5'b00001, dests(2,0,0,0,0), 5'b00000, 5'b01000, 5'b00000, 5'b01000, 5'b00100);
        vecs[16] = mk(5'b00000, dests(0,0,0,0,0), 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        vecs[17] = mk(5'b00000, dests(0,0,0,0,0), 5'b00000, 5'b00001, 5'b00000, 5'b00001, 5'b00100);
        vecs[18] = mk(5'b00000, dests(0,0,0,0,0), 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        vecs[19] = mk(5'b00010, dests(0,4,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        vecs[20] = mk(5'b00000, dests(0,0,0,0,0), 5'b00000, 5'b00010, 5'b00000, 5'b00010, 5'b10000);
        vecs[21] = mk(5'b00010, dests(0,4,0,0,0), 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        vecs[22] = mk(5'b00000, dests(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        vecs[23] = mk(5'b00000, dests(0,0,0,0,0), 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000);

        do_reset();
        rst = 1'b1;
        step();
        check("reset_state", 128'({req_ack, req_err, in_locked, out_busy, route_sel, grant_cnt}), 128'(0));
        rst = 1'b0;

        for (int k = 0; k < 24; k++) begin
            req_valid = vecs[k].valid;
            req_dest = vecs[k].dest;
            tail_release = vecs[k].rel;
            step();
            check($sformatf("vec%0d", k), 128'({req_ack, req_err, in_locked, out_busy}),
                  128'({vecs[k].ack, vecs[k].err, vecs[k].locked, vecs[k].busy}));
        end
        req_valid = '0;
        tail_release = '0;
        check("table_route_sel", 128'(route_sel), 128'({3'd1, 3'd2, 3'd0, 3'd0, 3'd0}));
        check("table_grant_cnt", 128'(grant_cnt), 128'({16'd1, 16'd2, 16'd4, 16'd1, 16'd0}));

        req_valid = 5'b00111;
        req_dest = dests(1, 2, 3, 0, 0);
        step();
        req_valid = '0;
        step();
        check("pre_reset_busy", 128'({in_locked, out_busy}), 128'({5'b00111, 5'b01110}));
        rst = 1'b1;
        step();
        check("mid_reset_clear", 128'({req_ack, req_err, in_locked, out_busy, route_sel, grant_cnt}), 128'(0));
        rst = 1'b0;
        req_valid = 5'b10001;
        req_dest = dests(1, 0, 0, 0, 1);
        step();
        req_valid = '0;
        step();
        check("post_reset_ptr0_ack", 128'(req_ack), 128'(5'b00001));
        check("post_reset_sel_cnt", 128'({route_sel[5:3], grant_cnt[31:16]}), 128'({3'd0, 16'd1}));
        tail_release = 5'b00001;
        step();
        tail_release = '0;
        step();
        check("post_reset_next_ack", 128'(req_ack), 128'(5'b10000));
        tail_release = 5'b10000;
        step();
        tail_release = '0;

        do_reset();
        rr_order(0, 1, 4);
        req_valid = 5'b00010;
        req_dest = dests(0, 1, 0, 0, 0);
        step();
        req_valid = '0;
        step();
        check("ptr_setup_ack", 128'(req_ack), 128'(5'b00010));
        tail_release = 5'b00010;
        step();
        tail_release = '0;
        rr_order(4, 0, 1);
        check("rr_grant_cnt1", 128'(grant_cnt[31:16]), 128'(16'd7));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_allocator_rr.md
Name: switch_allocator_rr

Overview:
Parametrised successor to the mesh switch control: allocates router output ports to input ports for wormhole packets.
- Each input holds its reserved output from the head flit until tail release.
- Each output arbitrates round-robin, so no input starves; the old design used fixed lowest-index priority.
- Also adds an invalid-destination error path, per-output lock counters and a configurable number of ports, for mesh, torus and concentrated topologies.

Parameters:
INPUTS, 5, number of router input ports
OUTPUTS, 5, number of router output ports
SEL_WIDTH, $clog2(INPUTS) (min 1), width of one route_sel field
DEST_WIDTH, $clog2(OUTPUTS) (min 1), width of one destination field
CNT_WIDTH, 16, width of per-output grant counters

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  INPUTS  head flit present; input requests an output
req_dest  in  INPUTS*DEST_WIDTH  requested output per input, field i at [i*DEST_WIDTH +: DEST_WIDTH]
release  in  INPUTS  tail flit forwarded; free the held output
req_ack  out  INPUTS  one-cycle pulse: path reserved
req_err  out  INPUTS  one-cycle pulse: dest >= OUTPUTS, request dropped
in_locked  out  INPUTS  input currently holds an output
route_sel  out  OUTPUTS*SEL_WIDTH  crossbar select: input driving each output
out_busy  out  OUTPUTS  output currently reserved
grant_cnt  out  OUTPUTS*CNT_WIDTH  number of grants issued per output, saturating

Behaviour:
- Reset: every output is 0, every per-input FSM is IDLE, every round-robin pointer is 0.
- Reset mid-operation aborts all reservations in one cycle.
- Per-input FSM states are IDLE, REQ and HELD.
- IDLE to REQ: when req_valid[i]=1 and req_dest[i] < OUTPUTS.
  - The dest value is latched at that edge.
  - req_valid and req_dest are ignored thereafter until the FSM returns to IDLE.
- IDLE with req_valid[i]=1 and dest >= OUTPUTS: req_err[i] pulses in the next cycle and the FSM stays IDLE.
- Arbitration, per output o, combinational:
  - Candidates are inputs in REQ whose latched dest is o.
  - Arbitration happens only when out_busy[o]=0.
  - Winner is the first candidate scanning upward from ptr[o], wrapping INPUTS-1 to 0.
- REQ to HELD for the winner at the next edge. At the same edge:
  - out_busy[o] goes to 1.
  - route_sel[o] takes the winner index.
  - ptr[o] becomes (winner+1) mod INPUTS.
  - grant_cnt[o] increments, saturating at all-ones.
- req_ack[i] is high only in the first cycle of HELD. in_locked[i] is high for every cycle of HELD.
- Losers stay in REQ. No request is withdrawn.
- HELD to IDLE: when release[i]=1. At the same edge out_busy[dest] goes to 0.
  - route_sel[dest] keeps its value; it is don't-care while not busy.
  - release[i] in IDLE or REQ is ignored.
- Latency: req_valid sampled at edge k gives REQ after k; an uncontested grant gives HELD and req_ack in the cycle after edge k+1.
- Release-to-regrant: output is released at edge r, the next arbitration happens in cycle r..r+1, and req_ack follows edge r+1.
  - There is no same-cycle handover.
- Simultaneous events:
  - Release of output o and new requests for o in the same cycle: the requests only queue, because busy is still 1 during that cycle.
  - Release by input i and a new req_valid[i] in the same cycle: the new request is ignored because the FSM is still HELD; the source must re-present it.
- Distinct outputs are allocated independently in the same cycle. Multiple grants per cycle are legal.
- Invariants, checked by assertion:
  - Each output is held by at most one input.
  - out_busy[o] equals the OR over HELD inputs whose dest is o.

Decomposition:
- Package noc_switch_pkg holds:
  - the state encoding (IDLE=0, REQ=1, HELD=2, width 2);
  - the width helper functions (clog2 with min 1);
  - common router port-count constants.
- One sub-module: rr_arbiter.
  - Parameter N; inputs req[N], ptr; outputs gnt one-hot, gnt_idx, any_gnt.
  - One instance per output, via generate.
- FSMs, pointers and counters stay in the top module.

Test Plan:
- Reset, then input 2 requests dest 3 → req_ack[2] in the 2nd cycle after sampling; route_sel[3]=2; out_busy[3]=1; grant_cnt[3]=1.
- Inputs 0, 1 and 4 all request dest 1 and hold; each releases 3 cycles after its ack → grant order 0, 1, 4. With ptr[1]=2 at the start, the order is 4, 0, 1.
- Input 0 holds dest 2 while input 3 requests dest 2 → no ack while held. release[0] at edge r → req_ack[3] after edge r+1. Then release[3] with input 0 re-requesting dest 2 → input 0 granted, showing alternation.
- req_dest=7 with OUTPUTS=5 → req_err pulse of 1 cycle; no busy change; FSM IDLE.
- Inputs 0→1, 1→2, 2→3 requested in the same cycle → all three acks in the same cycle; route_sel fields are 0, 1 and 2 respectively.
- rst asserted while 3 outputs are busy → next cycle everything is 0. A request after reset is granted normally with ptr 0.
